// File: rtl/hynoc_ni_pkg.sv
// ---------------------------------------------------------------------------
// hynoc_ni_pkg
// Shared types and helpers for the NI packetizer:
//   - ni_state_e    : packetizer FSM states (IDLE / HEADER / PAYLOAD)
//   - HDR_MARK_BIT  : header marker bit position for the default 32-bit payload
//   - pack_header / pack_payload : build a flit from a payload-width word.
//     They work on a 64-bit carrier so any PAYLOAD_WIDTH up to 64 can use them;
//     the caller truncates the result to its own FLIT_WIDTH.
// ---------------------------------------------------------------------------
package hynoc_ni_pkg;

   localparam int DEF_PAYLOAD_WIDTH = 32;
   localparam int HDR_MARK_BIT      = DEF_PAYLOAD_WIDTH;
   localparam int MAX_PW            = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } ni_state_e;

   // Word sits in the low pw bits, the marker lands directly above it.
   function automatic logic [MAX_PW:0] pack_flit(input logic is_hdr,
                                                 input logic [MAX_PW-1:0] word,
                                                 input int pw);
      logic [MAX_PW:0] f;
      f = {1'b0, word};
      f[pw[6:0]] = is_hdr;
      return f;
   endfunction

   function automatic logic [MAX_PW:0] pack_header(input logic [MAX_PW-1:0] word,
                                                   input int pw);
      return pack_flit(1'b1, word, pw);
   endfunction

   function automatic logic [MAX_PW:0] pack_payload(input logic [MAX_PW-1:0] word,
                                                    input int pw);
      return pack_flit(1'b0, word, pw);
   endfunction

endpackage

// File: rtl/hynoc_ni_packetizer_if.sv
// ---------------------------------------------------------------------------
// hynoc_ni_packetizer_if
// Bundles the packet request, payload stream and router ingress signals.
//   master : the packetizer side (drives ready/done/busy/ingress_*)
//   slave  : the environment side (drives requests, payload and FIFO level)
// ---------------------------------------------------------------------------
interface hynoc_ni_packetizer_if #(
   parameter int PAYLOAD_WIDTH   = 32,
   parameter int LEN_WIDTH       = 8,
   parameter int LOG2_FIFO_DEPTH = 5
);
   localparam int FLIT_WIDTH = PAYLOAD_WIDTH + 1;

   logic                       pkt_start;
   logic [PAYLOAD_WIDTH-1:0]   pkt_header;
   logic [LEN_WIDTH-1:0]       pkt_len;
   logic                       pkt_start_ready;
   logic                       pld_valid;
   logic [PAYLOAD_WIDTH-1:0]   pld_data;
   logic                       pld_ready;
   logic                       pkt_done;
   logic                       busy;
   logic                       ingress_write;
   logic [FLIT_WIDTH-1:0]      ingress_data;
   logic [LOG2_FIFO_DEPTH:0]   ingress_fifo_level;

   modport master (
      input  pkt_start, pkt_header, pkt_len, pld_valid, pld_data, ingress_fifo_level,
      output pkt_start_ready, pld_ready, pkt_done, busy, ingress_write, ingress_data
   );

   modport slave (
      output pkt_start, pkt_header, pkt_len, pld_valid, pld_data, ingress_fifo_level,
      input  pkt_start_ready, pld_ready, pkt_done, busy, ingress_write, ingress_data
   );
endinterface

// File: rtl/hynoc_ni_credit_tracker.sv
// ---------------------------------------------------------------------------
// hynoc_ni_credit_tracker
// Decides whether one more flit may be written to the router ingress FIFO.
// The reported FIFO level lags writes by LEVEL_LATENCY cycles, so the writes
// of that window are remembered and added to the level before comparing.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   wr_next     : the write strobe being registered this cycle
//   fifo_level  : router ingress FIFO occupancy (lagging)
//   can_write   : level + inflight < 2^LOG2_FIFO_DEPTH
// ---------------------------------------------------------------------------
module hynoc_ni_credit_tracker #(
   parameter int LOG2_FIFO_DEPTH = 5,
   parameter int LEVEL_LATENCY   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_next,
   input  logic [LOG2_FIFO_DEPTH:0] fifo_level,
   output logic                     can_write
);
   localparam int CW = LOG2_FIFO_DEPTH + 2;
   localparam logic [CW-1:0] DEPTH = CW'(2 ** LOG2_FIFO_DEPTH);

   // wr_hist[0] mirrors the write currently driven on the port,
   // wr_hist[i] the write driven i cycles earlier.
   logic [LEVEL_LATENCY-1:0] wr_hist;
   logic [CW-1:0]            inflight;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_hist <= '0;
      else        wr_hist <= LEVEL_LATENCY'({wr_hist, wr_next});
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LEVEL_LATENCY; i++)
         inflight = inflight + CW'(wr_hist[i]);
   end

   // Extra headroom bit keeps the sum from wrapping.
   assign can_write = (CW'(fifo_level) + inflight) < DEPTH;

endmodule

// File: rtl/hynoc_ni_packetizer.sv
// ---------------------------------------------------------------------------
// hynoc_ni_packetizer
// Network-interface packetizer feeding one router ingress port. A packet
// request (header word + payload length) produces one header flit followed
// by pkt_len payload flits taken from a valid/ready stream. Writes are
// throttled so the router ingress FIFO can never overflow.
// Ports:
//   ni_clk, ni_arst_n : clock, async active-low reset
//   nif (master)      : pkt_start/pkt_header/pkt_len/pkt_start_ready,
//                       pld_valid/pld_data/pld_ready, pkt_done, busy,
//                       ingress_write/ingress_data, ingress_fifo_level
//   stat_* (only with HYNOC_NI_STATS_EN defined): packet, flit and
//                       stall-cycle counters, wrapping modulo 2^32
// Flits: header = {1, pkt_header}, payload = {0, pld_data}. All flit outputs
// are registered: a word accepted at edge t is on the port during cycle t+1.
// ---------------------------------------------------------------------------
module hynoc_ni_packetizer
   import hynoc_ni_pkg::*;
#(
   parameter int PAYLOAD_WIDTH   = 32,
   parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1,
   parameter int LOG2_FIFO_DEPTH = 5,
   parameter int LEVEL_LATENCY   = 2,
   parameter int LEN_WIDTH       = 8
) (
   input  logic                  ni_clk,
   input  logic                  ni_arst_n,
   hynoc_ni_packetizer_if.master nif
`ifdef HYNOC_NI_STATS_EN
   ,
   output logic [31:0]           stat_pkt_count,
   output logic [31:0]           stat_flit_count,
   output logic [31:0]           stat_stall_cycles
`endif
);

   ni_state_e                state_q, state_n;
   logic [PAYLOAD_WIDTH-1:0] hdr_q, hdr_n;
   // Holds the latched length in HEADER, then the words still to accept.
   logic [LEN_WIDTH-1:0]     rem_q, rem_n;
   logic                     wr_q, wr_n;
   logic                     done_q, done_n;
   logic [FLIT_WIDTH-1:0]    data_q, data_n;
   logic                     can_write;
   logic                     start_rdy, pld_rdy;

   hynoc_ni_credit_tracker #(
      .LOG2_FIFO_DEPTH (LOG2_FIFO_DEPTH),
      .LEVEL_LATENCY   (LEVEL_LATENCY)
   ) u_credit (
      .clk        (ni_clk),
      .rst_n      (ni_arst_n),
      .wr_next    (wr_n),
      .fifo_level (nif.ingress_fifo_level),
      .can_write  (can_write)
   );

   always_ff @(posedge ni_clk or negedge ni_arst_n) begin
      if (!ni_arst_n) begin
         state_q <= IDLE;
         hdr_q   <= '0;
         rem_q   <= '0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_n;
         hdr_q   <= hdr_n;
         rem_q   <= rem_n;
         wr_q    <= wr_n;
         done_q  <= done_n;
         data_q  <= data_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      hdr_n     = hdr_q;
      rem_n     = rem_q;
      wr_n      = 1'b0;
      done_n    = 1'b0;
      data_n    = data_q;   // flit data holds between writes
      start_rdy = 1'b0;
      pld_rdy   = 1'b0;
      case (state_q)
         IDLE: begin
            start_rdy = 1'b1;
            if (nif.pkt_start) begin
               hdr_n   = nif.pkt_header;
               rem_n   = nif.pkt_len;
               state_n = HEADER;
            end
         end
         HEADER: begin
            if (can_write) begin
               wr_n   = 1'b1;
               data_n = FLIT_WIDTH'(pack_header(MAX_PW'(hdr_q), PAYLOAD_WIDTH));
               if (rem_q == '0) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            pld_rdy = can_write;
            if (nif.pld_valid && can_write) begin
               wr_n   = 1'b1;
               data_n = FLIT_WIDTH'(pack_payload(MAX_PW'(nif.pld_data), PAYLOAD_WIDTH));
               rem_n  = rem_q - 1'b1;
               if (rem_q == LEN_WIDTH'(1)) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign nif.pkt_start_ready = start_rdy;
   assign nif.pld_ready       = pld_rdy;
   assign nif.busy            = (state_q != IDLE);
   assign nif.ingress_write   = wr_q;
   assign nif.ingress_data    = data_q;
   assign nif.pkt_done        = done_q;

`ifdef HYNOC_NI_STATS_EN
   always_ff @(posedge ni_clk or negedge ni_arst_n) begin
      if (!ni_arst_n) begin
         stat_pkt_count    <= '0;
         stat_flit_count   <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (done_q) stat_pkt_count  <= stat_pkt_count + 32'd1;
         if (wr_q)   stat_flit_count <= stat_flit_count + 32'd1;
         if ((state_q != IDLE) && !can_write)
            stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hynoc_ni_packetizer.sv
// Directed bench for hynoc_ni_packetizer. The router ingress FIFO is modelled
// as a counter whose reported level lags each write by two cycles and which
// can optionally pop one entry every fourth cycle.
module tb_hynoc_ni_packetizer;
   localparam int PW = 32;
   localparam int LW = 8;
   localparam int LD = 5;

   logic clk = 1'b0;
   logic ni_arst_n;
   always #5 clk = ~clk;

   hynoc_ni_packetizer_if #(.PAYLOAD_WIDTH(PW), .LEN_WIDTH(LW), .LOG2_FIFO_DEPTH(LD)) nif ();

`ifdef HYNOC_NI_STATS_EN
   logic [31:0] s_pkt, s_flit, s_stall;
`endif

   hynoc_ni_packetizer #(
      .PAYLOAD_WIDTH(PW), .FLIT_WIDTH(PW+1), .LOG2_FIFO_DEPTH(LD),
      .LEVEL_LATENCY(2), .LEN_WIDTH(LW)
   ) dut (
      .ni_clk    (clk),
      .ni_arst_n (ni_arst_n),
      .nif       (nif)
`ifdef HYNOC_NI_STATS_EN
      ,
      .stat_pkt_count    (s_pkt),
      .stat_flit_count   (s_flit),
      .stat_stall_cycles (s_stall)
`endif
   );

   // ---------------- router FIFO level model ----------------
   logic [5:0] level;
   logic       d1;
   logic [1:0] dph;
   bit         drain_en;
   bit         ovf;
   assign nif.ingress_fifo_level = level;

   always @(posedge clk or negedge ni_arst_n) begin
      if (!ni_arst_n) begin
         level <= '0;
         d1    <= 1'b0;
         dph   <= '0;
      end else begin
         d1    <= nif.ingress_write;
         dph   <= drain_en ? dph + 2'd1 : 2'd0;
         level <= level + 6'(d1) - 6'((drain_en && dph == 2'd3 && level != 0) ? 1 : 0);
      end
   end

   // true occupancy = reported level + writes not yet reflected
   always @(negedge clk)
      if (int'(level) + int'(d1) + int'(nif.ingress_write) > 32) ovf = 1'b1;

   // ---------------- write log ----------------
   logic [63:0] log_d[$];
   logic        log_done[$];
   int          done_cnt;
   always @(posedge clk) begin
      if (nif.ingress_write) begin
         log_d.push_back(64'(nif.ingress_data));
         log_done.push_back(nif.pkt_done);
      end
      if (nif.pkt_done) done_cnt++;
   end

   // ---------------- checking ----------------
   int n_chk, n_pass, n_fail;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   int wi;      // next payload word value
   bit toggle;  // flip pld_valid every cycle

   // One clock: sample handshakes, advance, update stimulus #1 after the edge.
   task automatic step();
      bit pa, sa;
      pa = nif.pld_valid && nif.pld_ready;
      sa = nif.pkt_start && nif.pkt_start_ready;
      @(posedge clk); #1;
      if (pa) begin wi++; nif.pld_data = 32'(wi); end
      if (sa) nif.pkt_start = 1'b0;
      if (toggle) nif.pld_valid = !nif.pld_valid;
   endtask

   task automatic do_reset();
      ni_arst_n      = 1'b0;
      nif.pkt_start  = 1'b0;
      nif.pld_valid  = 1'b0;
      drain_en       = 1'b0;
      toggle         = 1'b0;
      repeat (2) @(posedge clk);
      #1 ni_arst_n = 1'b1;
      log_d.delete();
      log_done.delete();
   endtask

   task automatic start_pkt(input logic [31:0] hdr, input logic [7:0] len);
      nif.pkt_header = hdr;
      nif.pkt_len    = len;
      nif.pkt_start  = 1'b1;
   endtask

   initial begin
      int d0;
      nif.pkt_header = '0; nif.pkt_len = '0; nif.pld_data = '0;
      ovf = 1'b0; done_cnt = 0;
      do_reset();

      // ---- reset state ----
      chk("rst_write", nif.ingress_write, 0);
      chk("rst_data", nif.ingress_data, 0);
      chk("rst_done", nif.pkt_done, 0);
      chk("rst_busy", nif.busy, 0);
      chk("rst_pld_ready", nif.pld_ready, 0);
      chk("rst_start_ready", nif.pkt_start_ready, 1);

      // ---- T1: header A5, len 3, continuous payload ----
      wi = 1; nif.pld_data = 32'd1; nif.pld_valid = 1'b1;
      start_pkt(32'h0000_00A5, 8'd3);
      step();
      chk("t1_busy_hdr", nif.busy, 1);
      chk("t1_no_write_hdr", nif.ingress_write, 0);
      chk("t1_pld_ready_hdr", nif.pld_ready, 0);
      chk("t1_start_ready_hdr", nif.pkt_start_ready, 0);
      step();
      chk("t1_f0_wr", nif.ingress_write, 1);
      chk("t1_f0", nif.ingress_data, 64'h1_0000_00A5);
      chk("t1_pld_ready", nif.pld_ready, 1);
      step();
      chk("t1_f1", nif.ingress_data, 64'h0_0000_0001);
      chk("t1_f1_wr", nif.ingress_write, 1);
      chk("t1_f1_done", nif.pkt_done, 0);
      step();
      chk("t1_f2", nif.ingress_data, 64'h0_0000_0002);
      step();
      chk("t1_f3", nif.ingress_data, 64'h0_0000_0003);
      chk("t1_f3_wr", nif.ingress_write, 1);
      chk("t1_done", nif.pkt_done, 1);
      chk("t1_idle", nif.busy, 0);
      chk("t1_start_ready", nif.pkt_start_ready, 1);
      nif.pld_valid = 1'b0;
      step();
      chk("t1_after_wr", nif.ingress_write, 0);
      chk("t1_after_done", nif.pkt_done, 0);

      // ---- T2: zero-length packet ----
      start_pkt(32'h7, 8'd0);
      step();
      chk("t2_busy", nif.busy, 1);
      chk("t2_no_wr", nif.ingress_write, 0);
      step();
      chk("t2_f0", nif.ingress_data, 64'h1_0000_0007);
      chk("t2_wr", nif.ingress_write, 1);
      chk("t2_done", nif.pkt_done, 1);
      chk("t2_idle", nif.busy, 0);
      step();
      chk("t2_after_wr", nif.ingress_write, 0);

      // ---- T3: FIFO never read, len 40 -> exactly 32 writes then stall ----
      do_reset();
      wi = 1; nif.pld_data = 32'd1; nif.pld_valid = 1'b1;
      start_pkt(32'h33, 8'd40);
      repeat (100) step();
      chk("t3_writes", log_d.size(), 32);
      chk("t3_pld_ready_low", nif.pld_ready, 0);
      chk("t3_accepted", wi, 32);
      chk("t3_level_full", level, 32);
      chk("t3_busy", nif.busy, 1);
      chk("t3_no_ovf", ovf, 0);

      // ---- T4: drain 1 per 4 cycles -> remaining 9 flits complete ----
      d0 = done_cnt;
      drain_en = 1'b1;
      for (int c = 0; c < 400 && done_cnt == d0; c++) step();
      nif.pld_valid = 1'b0;
      repeat (4) step();
      chk("t4_done_once", done_cnt - d0, 1);
      chk("t4_writes", log_d.size(), 41);
      if (log_d.size() == 41) begin
         chk("t4_hdr", log_d[0], 64'h1_0000_0033);
         for (int i = 1; i < 41; i++)
            chk($sformatf("t4_word%0d", i), log_d[i], 64'(i));
         chk("t4_last_done", log_done[40], 1);
         chk("t4_mid_done", log_done[39], 0);
      end
      chk("t4_no_ovf", ovf, 0);
      chk("t4_idle", nif.busy, 0);

      // ---- T5: toggling valid, second request held during first packet ----
      do_reset();
      wi = 32'h101; nif.pld_data = 32'h101; nif.pld_valid = 1'b1;
      start_pkt(32'h55, 8'd4);
      step();
      start_pkt(32'h66, 8'd1);
      chk("t5_start_blocked", nif.pkt_start_ready, 0);
      toggle = 1'b1;
      d0 = done_cnt;
      for (int c = 0; c < 80 && (done_cnt - d0) < 2; c++) step();
      toggle = 1'b0; nif.pld_valid = 1'b0;
      repeat (3) step();
      chk("t5_done_cnt", done_cnt - d0, 2);
      chk("t5_writes", log_d.size(), 7);
      if (log_d.size() == 7) begin
         chk("t5_f0", log_d[0], 64'h1_0000_0055);
         chk("t5_f1", log_d[1], 64'h0_0000_0101);
         chk("t5_f2", log_d[2], 64'h0_0000_0102);
         chk("t5_f3", log_d[3], 64'h0_0000_0103);
         chk("t5_f4", log_d[4], 64'h0_0000_0104);
         chk("t5_f4_done", log_done[4], 1);
         chk("t5_f5_hdr2", log_d[5], 64'h1_0000_0066);
         chk("t5_f5_done", log_done[5], 0);
         chk("t5_f6", log_d[6], 64'h0_0000_0105);
         chk("t5_f6_done", log_done[6], 1);
      end
      chk("t5_words_taken", wi, 32'h106);

      // ---- T6: async reset mid-payload, then a clean packet ----
      do_reset();
      wi = 32'h201; nif.pld_data = 32'h201; nif.pld_valid = 1'b1;
      start_pkt(32'h77, 8'd5);
      step();
      step();
      step();
      step();
      chk("t6_w2_wr", nif.ingress_write, 1);
      chk("t6_w2", nif.ingress_data, 64'h0_0000_0202);
      #1 ni_arst_n = 1'b0;
      #1;
      chk("t6_rst_wr", nif.ingress_write, 0);
      chk("t6_rst_data", nif.ingress_data, 0);
      chk("t6_rst_busy", nif.busy, 0);
      chk("t6_rst_pld_ready", nif.pld_ready, 0);
      chk("t6_rst_done", nif.pkt_done, 0);
      chk("t6_rst_start_ready", nif.pkt_start_ready, 1);
      @(posedge clk); #1 ni_arst_n = 1'b1;
      wi = 32'h301; nif.pld_data = 32'h301; nif.pld_valid = 1'b1;
      start_pkt(32'h88, 8'd1);
      step();
      chk("t6_new_hdr_wait", nif.ingress_write, 0);
      step();
      chk("t6_new_hdr", nif.ingress_data, 64'h1_0000_0088);
      chk("t6_new_hdr_wr", nif.ingress_write, 1);
      step();
      chk("t6_new_word", nif.ingress_data, 64'h0_0000_0301);
      chk("t6_new_done", nif.pkt_done, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
